fir_seq: RTL and testbench

Sequencer for the FIR engine: owns the block-level start/done/idle state and drives all tap-RAM and data-RAM addressing. It accepts one input sample per output, keeps the last Tape_Num samples in the data RAM as a circular buffer, and walks taps and samples through an external MAC datapath. It emits each result on the output stream. It sits between the AXI-Lite config block (ap_start, data_length) and the MAC/BRAM datapath.

---
 rtl/fir_seq.sv | 182 ++++++++++++++++++
 tb/tb_fir_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_seq.sv
// fir_seq: control sequencer for the FIR engine. Owns start/done/idle, clears and
// fills the circular sample buffer in data RAM, walks taps against samples through
// an external MAC, and presents each accumulated result on the output stream.
module fir_seq #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   ap_start,
  input  logic [31:0]            data_length,
  output logic                   ap_idle,
  output logic                   ap_done,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  output logic                   ss_tready,
  input  logic                   sm_tready,
  output logic                   sm_tvalid,
  output logic                   sm_tlast,
  output logic                   tap_EN,
  output logic [pADDR_WIDTH-1:0] tap_A,
  output logic                   data_EN,
  output logic [3:0]             data_WE,
  output logic [pADDR_WIDTH-1:0] data_A,
  output logic [pDATA_WIDTH-1:0] data_Di,
  output logic                   mac_en,
  output logic                   mac_clr
);

  localparam int CW = (Tape_Num > 1) ? $clog2(Tape_Num) : 1;
  localparam logic [CW-1:0] LastIdx = CW'(Tape_Num - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StClear  = 3'd1;
  localparam logic [2:0] StWaitIn = 3'd2;
  localparam logic [2:0] StCalc   = 3'd3;
  localparam logic [2:0] StDrain  = 3'd4;
  localparam logic [2:0] StOut    = 3'd5;
  localparam logic [2:0] StDone   = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [31:0]   len_q, len_d;
  logic [31:0]   out_cnt_q, out_cnt_d;
  logic          done_q, done_d;
  logic [CW-1:0] wptr_q, wptr_d;
  // Shared step counter: c in CLEAR, k in CALC.
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   rd_idx;

  // Next-state and counter update.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    out_cnt_d = out_cnt_q;
    done_d    = done_q;
    wptr_d    = wptr_q;
    cnt_d     = cnt_q;
    case (state_q)
      StIdle: begin
        if (ap_start) begin
          len_d     = data_length;
          done_d    = 1'b0;
          wptr_d    = '0;
          out_cnt_d = '0;
          cnt_d     = '0;
          state_d   = StClear;
        end
      end
      StClear: begin
        if (cnt_q == LastIdx) begin
          cnt_d   = '0;
          state_d = (len_q == 32'd0) ? StDone : StWaitIn;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StWaitIn: begin
        if (ss_tvalid) begin
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (cnt_q == LastIdx) begin
          cnt_d   = '0;
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDrain: state_d = StOut;
      StOut: begin
        if (sm_tready) begin
          wptr_d    = (wptr_q == LastIdx) ? '0 : wptr_q + CW'(1);
          out_cnt_d = out_cnt_q + 32'd1;
          state_d   = (out_cnt_q + 32'd1 == len_q) ? StDone : StWaitIn;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      state_q   <= StIdle;
      len_q     <= '0;
      out_cnt_q <= '0;
      done_q    <= 1'b0;
      wptr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      out_cnt_q <= out_cnt_d;
      done_q    <= done_d;
      wptr_q    <= wptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Sample index for tap k is (wptr - k) mod Tape_Num, newest sample first.
  always_comb begin
    if (wptr_q >= cnt_q) begin
      rd_idx = {1'b0, wptr_q} - {1'b0, cnt_q};
    end else begin
      rd_idx = {1'b0, wptr_q} + (CW + 1)'(Tape_Num) - {1'b0, cnt_q};
    end
  end

  // Output decode from registered state; only the WAIT_IN write path looks at ss_tvalid.
  always_comb begin
    ap_idle   = (state_q == StIdle);
    ap_done   = done_q;
    ss_tready = 1'b0;
    sm_tvalid = 1'b0;
    sm_tlast  = 1'b0;
    tap_EN    = 1'b0;
    tap_A     = '0;
    data_EN   = 1'b0;
    data_WE   = 4'h0;
    data_A    = '0;
    data_Di   = '0;
    // Products lag addresses by one cycle: k=1..Tape_Num-1 in CALC plus DRAIN.
    mac_en    = ((state_q == StCalc) && (cnt_q != '0)) || (state_q == StDrain);
    mac_clr   = ((state_q == StCalc) && (cnt_q == CW'(1))) ||
                ((state_q == StDrain) && (Tape_Num == 1));
    case (state_q)
      StClear: begin
        data_EN = 1'b1;
        data_WE = 4'hF;
        data_A  = pADDR_WIDTH'({cnt_q, 2'b00});
      end
      StWaitIn: begin
        ss_tready = 1'b1;
        data_EN   = 1'b1;
        if (ss_tvalid) begin
          data_WE = 4'hF;
          data_A  = pADDR_WIDTH'({wptr_q, 2'b00});
          data_Di = ss_tdata;
        end
      end
      StCalc: begin
        tap_EN  = 1'b1;
        tap_A   = pADDR_WIDTH'({cnt_q, 2'b00});
        data_EN = 1'b1;
        data_A  = pADDR_WIDTH'({rd_idx, 2'b00});
      end
      StOut: begin
        sm_tvalid = 1'b1;
        sm_tlast  = (out_cnt_q == len_q - 32'd1);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fir_seq.sv
// tb_fir_seq: drives fir_seq with a tap RAM, a data RAM and a MAC stand-in, and
// checks every presented output against a direct convolution of the run's inputs.
module tb_fir_seq;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int N  = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ap_start;
  logic [31:0]   data_length;
  logic          ap_idle, ap_done;
  logic          ss_tvalid;
  logic [DW-1:0] ss_tdata;
  logic          ss_tready;
  logic          sm_tready, sm_tvalid, sm_tlast;
  logic          tap_EN, data_EN;
  logic [AW-1:0] tap_A, data_A;
  logic [3:0]    data_WE;
  logic [DW-1:0] data_Di;
  logic          mac_en, mac_clr;

  always #5 clk = ~clk;

  fir_seq #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(N)) dut (
    .axis_clk    (clk),
    .axis_rst_n  (rst_n),
    .ap_start    (ap_start),
    .data_length (data_length),
    .ap_idle     (ap_idle),
    .ap_done     (ap_done),
    .ss_tvalid   (ss_tvalid),
    .ss_tdata    (ss_tdata),
    .ss_tready   (ss_tready),
    .sm_tready   (sm_tready),
    .sm_tvalid   (sm_tvalid),
    .sm_tlast    (sm_tlast),
    .tap_EN      (tap_EN),
    .tap_A       (tap_A),
    .data_EN     (data_EN),
    .data_WE     (data_WE),
    .data_A      (data_A),
    .data_Di     (data_Di),
    .mac_en      (mac_en),
    .mac_clr     (mac_clr)
  );

  // Datapath stand-in: 1-cycle read RAMs and the accumulator.
  logic [DW-1:0] tap_mem [N];
  logic [DW-1:0] data_mem[N];
  logic [DW-1:0] tap_do, data_do, acc;

  always @(posedge clk) begin
    if (tap_EN && int'(tap_A >> 2) < N) tap_do <= tap_mem[int'(tap_A >> 2)];
    if (data_EN && int'(data_A >> 2) < N) begin
      if (data_WE == 4'hF) data_mem[int'(data_A >> 2)] <= data_Di;
      data_do <= data_mem[int'(data_A >> 2)];
    end
    if (mac_en) acc <= mac_clr ? tap_do * data_do : acc + tap_do * data_do;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state for the current run.
  logic [31:0] xs[$];
  int          exp_len;
  int          out_idx;
  logic [31:0] got[$];
  int          tlast_cnt;
  int          tready_hi;
  logic [AW-1:0] clr_addrs[$], wr_addrs[$], rd_addrs[$], tap_addrs[$];

  // y[n] = sum_k tap[k] * x[n-k], with x before the run start taken as zero.
  function automatic logic [31:0] model_y(input int n);
    logic [31:0] s = 32'd0;
    for (int k = 0; k < N; k++) begin
      if (n - k >= 0 && n - k < xs.size()) s = s + tap_mem[k] * xs[n - k];
    end
    return s;
  endfunction

  // Compare process: observes every cycle on the falling edge.
  initial begin
    logic          hold_q = 1'b0;
    logic [DW-1:0] hold_acc = '0;
    logic          hold_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_q = 1'b0;
      end else begin
        if (data_EN && data_WE == 4'hF) begin
          if (ss_tready) wr_addrs.push_back(data_A);
          else clr_addrs.push_back(data_A);
        end
        if (tap_EN) begin
          rd_addrs.push_back(data_A);
          tap_addrs.push_back(tap_A);
        end
        if (ss_tready) tready_hi++;
        if (hold_q) begin
          check("hold_valid", sm_tvalid, 1'b1);
          check("hold_data", acc, hold_acc);
          check("hold_last", sm_tlast, hold_last);
        end
        if (sm_tvalid) begin
          check("ss_tready_in_out", ss_tready, 1'b0);
          check("y", acc, model_y(out_idx));
          check("tlast", sm_tlast, out_idx == exp_len - 1);
          if (sm_tready) begin
            got.push_back(acc);
            if (sm_tlast) tlast_cnt++;
            out_idx++;
          end
        end
        hold_q    = sm_tvalid && !sm_tready;
        hold_acc  = acc;
        hold_last = sm_tlast;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int len);
    clr_addrs.delete(); wr_addrs.delete(); rd_addrs.delete(); tap_addrs.delete();
    got.delete();
    tlast_cnt   = 0;
    tready_hi   = 0;
    out_idx     = 0;
    exp_len     = len;
    data_length = len;
    ap_start    = 1'b1;
    tick();
    ap_start    = 1'b0;
  endtask

  task automatic wait_accept(input logic [31:0] x);
    int t = 0;
    ss_tvalid = 1'b1;
    ss_tdata  = x;
    do begin @(negedge clk); t++; end while (!ss_tready && t < 200);
    check("in_accept", ss_tready, 1'b1);
    tick();
    ss_tvalid = 1'b0;
    ss_tdata  = '0;
  endtask

  // One sample in, one result out; bp>0 stalls the output and pokes ss_tvalid meanwhile.
  task automatic send(input logic [31:0] x, input int bp);
    int t = 0;
    if (bp > 0) sm_tready = 1'b0;
    wait_accept(x);
    do begin @(negedge clk); t++; end while (!sm_tvalid && t < 200);
    check("out_valid", sm_tvalid, 1'b1);
    if (bp > 0) begin
      ss_tvalid = 1'b1;
      ss_tdata  = 32'd99;
      repeat (bp) tick();
      ss_tvalid = 1'b0;
      ss_tdata  = '0;
      sm_tready = 1'b1;
    end
    tick();
  endtask

  task automatic finish_run();
    int t = 0;
    while (!ap_done && t < 50) begin tick(); t++; end
    check("ap_done_end", ap_done, 1'b1);
    check("ap_idle_end", ap_idle, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; ap_start = 1'b0; data_length = '0;
    ss_tvalid = 1'b0; ss_tdata = '0; sm_tready = 1'b1;
    for (int i = 0; i < N; i++) begin
      tap_mem[i]  = 32'd1;
      data_mem[i] = 32'h0BAD;
    end

    // Reset values.
    repeat (3) tick();
    check("rst_flags", {ap_idle, ap_done, ss_tready, sm_tvalid, sm_tlast, tap_EN, data_EN,
                        data_WE, mac_en, mac_clr}, 13'b1_0000_0000_0000);
    check("rst_addr", {tap_A, data_A}, '0);
    check("rst_di", data_Di, '0);
    rst_n = 1'b1;
    repeat (5) begin
      tick();
      check("idle_hold", {ap_idle, ap_done, ss_tready}, 3'b100);
    end

    // Basic run, taps all 1, with output backpressure on the first result.
    xs = '{32'd1, 32'd2, 32'd3};
    start_run(3);
    send(32'd1, 5);
    send(32'd2, 0);
    send(32'd3, 0);
    finish_run();
    check("clr_count", clr_addrs.size(), N);
    for (int i = 0; i < N && i < clr_addrs.size(); i++) check("clr_addr", clr_addrs[i], 4 * i);
    check("rd_count", rd_addrs.size(), 3 * N);
    for (int k = 0; k < N && k < rd_addrs.size(); k++) begin
      check("calc_data_A", rd_addrs[k], 4 * ((N - k) % N));
      check("calc_tap_A", tap_addrs[k], 4 * k);
    end
    check("basic_n_out", got.size(), 3);
    if (got.size() == 3) begin
      check("basic_y0", got[0], 32'd1);
      check("basic_y1", got[1], 32'd3);
      check("basic_y2", got[2], 32'd6);
    end
    check("basic_tlast_cnt", tlast_cnt, 1);
    check("basic_wr_count", wr_addrs.size(), 3);
    if (wr_addrs.size() == 3) check("basic_wr_addrs", {wr_addrs[0], wr_addrs[1], wr_addrs[2]},
                                    {12'h0, 12'h4, 12'h8});

    // Zero length: CLEAR only, then done.
    start_run(0);
    check("done_cleared", ap_done, 1'b0);
    n = 1;
    while (!ap_done && n < 50) begin tick(); n++; end
    check("zero_done_cycle", n, N + 2);
    check("zero_clr_count", clr_addrs.size(), N);
    check("zero_no_tready", tready_hi, 0);
    check("zero_idle", ap_idle, 1'b1);

    // Wrap-around: taps 1..11, ramp 1..13.
    for (int i = 0; i < N; i++) tap_mem[i] = i + 1;
    xs.delete();
    for (int i = 1; i <= 13; i++) xs.push_back(i);
    start_run(13);
    for (int i = 1; i <= 13; i++) send(i, 0);
    finish_run();
    check("wrap_wr_count", wr_addrs.size(), 13);
    if (wr_addrs.size() == 13) begin
      check("wrap_wr10", wr_addrs[10], 12'h028);
      check("wrap_wr11", wr_addrs[11], 12'h000);
    end
    check("wrap_n_out", got.size(), 13);
    if (got.size() == 13) begin
      check("wrap_y0", got[0], 32'd1);
      check("wrap_y11", got[11], 32'd352);
      check("wrap_y12", got[12], 32'd418);
    end
    check("wrap_tlast_cnt", tlast_cnt, 1);

    // Reset during CALC of the second sample, then a fresh run.
    for (int i = 0; i < N; i++) tap_mem[i] = 32'd1;
    xs = '{32'd7, 32'd8, 32'd9, 32'd10, 32'd11};
    start_run(5);
    send(32'd7, 0);
    wait_accept(32'd8);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("midrst_state", {ap_idle, ap_done, sm_tvalid, ss_tready, tap_EN}, 5'b10000);
    xs = '{32'd1, 32'd2};
    start_run(2);
    send(32'd1, 0);
    send(32'd2, 0);
    finish_run();
    check("midrst_clr_count", clr_addrs.size(), N);
    check("midrst_n_out", got.size(), 2);
    if (got.size() == 2) begin
      check("midrst_y0", got[0], 32'd1);
      check("midrst_y1", got[1], 32'd3);
    end
    check("midrst_tlast_cnt", tlast_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
